// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared types, defaults and helpers for the switch debouncer
package sw_debounce_pkg;
  typedef enum logic [1:0] {LOW, CNT_UP, HIGH, CNT_DN} chan_state_t;
  localparam int DEFAULT_DB_CYCLES = 500000;
  // Index of the lowest set bit; 0 when no bit is set (callers guard on that case).
  function automatic int lsb_idx(input logic [63:0] v);
    int r;
    r = 0;
    for (int i = 63; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one switch channel with 2-flop synchronizer, stability counter and committed level
// Ports: clk, rst (async, active-high); i_sw raw pin; o_sw_db committed level;
//        o_rise/o_fall one-cycle strobes with the commit; o_commit high in the cycle a commit is taken.
module debounce_chan
  import sw_debounce_pkg::*;
#(
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
  output logic o_sw_db,
  output logic o_rise,
  output logic o_fall,
  output logic o_commit
);
  localparam int CNT_W = $clog2(DB_CYCLES);
  logic r_s1, r_s2, r_sw_db, r_rise, r_fall;
  logic [CNT_W-1:0] r_cnt;
  chan_state_t r_state;
  logic w_done;
  assign w_done = r_cnt == CNT_W'(DB_CYCLES - 1);
  // Combinational so the top can mark the channel pending on the same edge sw_db changes.
  assign o_commit = w_done && ((r_state == CNT_UP && r_s2) || (r_state == CNT_DN && !r_s2));
  assign o_sw_db = r_sw_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_sw_db <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_cnt <= '0;
      r_state <= LOW;
    end else begin
      r_s1 <= i_sw;
      r_s2 <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        LOW: if (r_s2) begin
          r_state <= CNT_UP;
          r_cnt <= CNT_W'(1);
        end
        CNT_UP: if (!r_s2) begin
          r_state <= LOW;
          r_cnt <= '0;
        end else if (w_done) begin
          r_state <= HIGH;
          r_sw_db <= 1'b1;
          r_rise <= 1'b1;
          r_cnt <= '0;
        end else r_cnt <= r_cnt + CNT_W'(1);
        HIGH: if (!r_s2) begin
          r_state <= CNT_DN;
          r_cnt <= CNT_W'(1);
        end
        CNT_DN: if (r_s2) begin
          r_state <= HIGH;
          r_cnt <= '0;
        end else if (w_done) begin
          r_state <= LOW;
          r_sw_db <= 1'b0;
          r_fall <= 1'b1;
          r_cnt <= '0;
        end else r_cnt <= r_cnt + CNT_W'(1);
        default: r_state <= LOW;
      endcase
    end
  end
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: debounced switch levels, edge strobes and a valid/ready change-event stream
// Ports: clk, rst (async, active-high); sw raw pins; sw_db/rise/fall per channel;
//        event_valid/event_ready handshake with event_idx/event_level; overrun sticky loss flag.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [IDX_W-1:0] event_idx,
  output logic             event_level,
  output logic             overrun
);
  logic [WIDTH-1:0] w_commit, w_clear, r_pending;
  logic [IDX_W-1:0] w_sel, r_event_idx;
  logic w_load, r_event_valid, r_event_level, r_overrun;
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(.DB_CYCLES(DB_CYCLES)) u_chan (
      .clk(clk),
      .rst(rst),
      .i_sw(sw[i]),
      .o_sw_db(sw_db[i]),
      .o_rise(rise[i]),
      .o_fall(fall[i]),
      .o_commit(w_commit[i])
    );
  end
  assign w_load = !r_event_valid || event_ready;
  assign w_sel = IDX_W'(lsb_idx(64'(r_pending)));
  assign w_clear = (w_load && |r_pending) ? WIDTH'(1) << w_sel : '0;
  assign event_valid = r_event_valid;
  assign event_idx = r_event_idx;
  assign event_level = r_event_level;
  assign overrun = r_overrun;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_event_valid <= 1'b0;
      r_event_idx <= '0;
      r_event_level <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // A commit landing on a bit being loaded this cycle re-arms it, so the newer change is kept.
      r_pending <= (r_pending & ~w_clear) | w_commit;
      if (|(w_commit & r_pending & ~w_clear)) r_overrun <= 1'b1;
      if (w_load) begin
        r_event_valid <= |r_pending;
        if (|r_pending) begin
          r_event_idx <= w_sel;
          r_event_level <= sw_db[w_sel];
        end
      end
    end
  end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: scoreboard-driven self-checking bench for sw_debounce (WIDTH=8, DB_CYCLES=4)
module tb_sw_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] sw = '0;
  logic event_ready = 1'b0;
  logic [7:0] sw_db, rise, fall;
  logic event_valid, event_level, overrun;
  logic [2:0] event_idx;
  int n_pass = 0;
  int n_total = 0;
  logic [3:0] exp_q[$];
  logic [3:0] e;

  sw_debounce #(.WIDTH(8), .DB_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .sw_db(sw_db),
    .rise(rise),
    .fall(fall),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_idx(event_idx),
    .event_level(event_level),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard: every accepted event is compared against the oldest expected {idx, level}.
  always @(negedge clk) begin
    if (!rst && event_valid && event_ready) begin
      n_total++;
      if (exp_q.size() == 0) $display("FAIL sb_unexpected: got idx=%0d level=%0d, queue empty", event_idx, event_level);
      else begin
        e = exp_q.pop_front();
        if ({event_idx, event_level} !== e) $display("FAIL sb_event: got idx=%0d level=%0d want idx=%0d level=%0d", event_idx, event_level, e[3:1], e[0]);
        else n_pass++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    repeat (4) tick();
    rst = 1'b1;
    sw = '0;
    event_ready = 1'b0;
    repeat (2) tick();
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_total++;
    if ({sw_db, rise, fall, event_valid, event_idx, event_level, overrun} !== 30'd0)
      $display("FAIL reset_outputs: got %h want 0", {sw_db, rise, fall, event_valid, event_idx, event_level, overrun});
    else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_clean_edge;
    do_reset();
    event_ready = 1'b1;
    sw[0] = 1'b1;
    exp_q.push_back({3'd0, 1'b1});
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_total++;
      if (sw_db[0] !== 1'b0) $display("FAIL clean_early: tick %0d sw_db0=%b want 0", k, sw_db[0]);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({sw_db[0], rise[0]} !== 2'b11) $display("FAIL clean_commit: got sw_db/rise=%b want 11", {sw_db[0], rise[0]});
    else n_pass++;
    tick();
    n_total++;
    if ({rise[0], event_valid, event_idx, event_level} !== {1'b0, 1'b1, 3'd0, 1'b1})
      $display("FAIL clean_event: got rise=%b v=%b idx=%0d lvl=%b want 0 1 0 1", rise[0], event_valid, event_idx, event_level);
    else n_pass++;
    tick();
    n_total++;
    if (event_valid !== 1'b0) $display("FAIL clean_drain: got valid=%b want 0", event_valid);
    else n_pass++;
  endtask

  task automatic test_bounce;
    logic [4:0] pat;
    do_reset();
    event_ready = 1'b1;
    pat = 5'b01101;
    for (int k = 0; k < 5; k++) begin
      sw[3] = pat[k];
      tick();
      n_total++;
      if ({sw_db[3], fall[3]} !== 2'b00) $display("FAIL bounce_toggle: step %0d got sw_db/fall=%b want 00", k, {sw_db[3], fall[3]});
      else n_pass++;
    end
    sw[3] = 1'b1;
    exp_q.push_back({3'd3, 1'b1});
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_total++;
      if ({sw_db[3], fall[3]} !== 2'b00) $display("FAIL bounce_hold: tick %0d got sw_db/fall=%b want 00", k, {sw_db[3], fall[3]});
      else n_pass++;
    end
    tick();
    n_total++;
    if ({sw_db[3], fall[3]} !== 2'b10) $display("FAIL bounce_commit: got sw_db/fall=%b want 10", {sw_db[3], fall[3]});
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    do_reset();
    sw[5] = 1'b1;
    sw[2] = 1'b1;
    exp_q.push_back({3'd2, 1'b1});
    exp_q.push_back({3'd5, 1'b1});
    for (int k = 0; k < 20 && !event_valid; k++) tick();
    n_total++;
    if (event_valid !== 1'b1) $display("FAIL simul_timeout: got valid=%b want 1", event_valid);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({event_valid, event_idx, event_level} !== {1'b1, 3'd2, 1'b1})
        $display("FAIL simul_hold: cycle %0d got v=%b idx=%0d lvl=%b want 1 2 1", k, event_valid, event_idx, event_level);
      else n_pass++;
      tick();
    end
    event_ready = 1'b1;
    tick();
    n_total++;
    if ({event_valid, event_idx, event_level} !== {1'b1, 3'd5, 1'b1})
      $display("FAIL simul_second: got v=%b idx=%0d lvl=%b want 1 5 1", event_valid, event_idx, event_level);
    else n_pass++;
    tick();
    n_total++;
    if ({event_valid, overrun} !== 2'b00) $display("FAIL simul_end: got valid/overrun=%b want 00", {event_valid, overrun});
    else n_pass++;
  endtask

  task automatic test_overrun;
    do_reset();
    sw[1] = 1'b1;
    repeat (8) tick();
    n_total++;
    if ({event_valid, event_idx, event_level, overrun} !== {1'b1, 3'd1, 1'b1, 1'b0})
      $display("FAIL ovr_first: got v=%b idx=%0d lvl=%b ovr=%b want 1 1 1 0", event_valid, event_idx, event_level, overrun);
    else n_pass++;
    sw[1] = 1'b0;
    repeat (8) tick();
    n_total++;
    if ({sw_db[1], event_valid, event_idx, event_level, overrun} !== {1'b0, 1'b1, 3'd1, 1'b1, 1'b0})
      $display("FAIL ovr_second: got db=%b v=%b idx=%0d lvl=%b ovr=%b want 0 1 1 1 0", sw_db[1], event_valid, event_idx, event_level, overrun);
    else n_pass++;
    sw[1] = 1'b1;
    repeat (8) tick();
    n_total++;
    if (overrun !== 1'b1) $display("FAIL ovr_third: got overrun=%b want 1", overrun);
    else n_pass++;
    exp_q.push_back({3'd1, 1'b1});
    exp_q.push_back({3'd1, 1'b1});
    event_ready = 1'b1;
    repeat (4) tick();
    n_total++;
    if ({event_valid, overrun} !== 2'b01) $display("FAIL ovr_sticky: got valid/overrun=%b want 01", {event_valid, overrun});
    else n_pass++;
  endtask

  task automatic test_fall;
    do_reset();
    event_ready = 1'b1;
    sw[4] = 1'b1;
    exp_q.push_back({3'd4, 1'b1});
    repeat (10) tick();
    sw[4] = 1'b0;
    exp_q.push_back({3'd4, 1'b0});
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_total++;
      if ({sw_db[4], fall[4]} !== 2'b10) $display("FAIL fall_early: tick %0d got sw_db/fall=%b want 10", k, {sw_db[4], fall[4]});
      else n_pass++;
    end
    tick();
    n_total++;
    if ({sw_db[4], fall[4], rise[4]} !== 3'b010) $display("FAIL fall_commit: got sw_db/fall/rise=%b want 010", {sw_db[4], fall[4], rise[4]});
    else n_pass++;
    tick();
    n_total++;
    if ({fall[4], event_valid, event_idx, event_level} !== {1'b0, 1'b1, 3'd4, 1'b0})
      $display("FAIL fall_event: got fall=%b v=%b idx=%0d lvl=%b want 0 1 4 0", fall[4], event_valid, event_idx, event_level);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    do_reset();
    sw[0] = 1'b1;
    repeat (8) tick();
    sw[6] = 1'b1;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if ({sw_db, rise, fall, event_valid, event_idx, event_level, overrun} !== 30'd0)
      $display("FAIL async_clear: got %h want 0", {sw_db, rise, fall, event_valid, event_idx, event_level, overrun});
    else n_pass++;
    sw = 8'h40;
    tick();
    exp_q.delete();
    rst = 1'b0;
    event_ready = 1'b1;
    exp_q.push_back({3'd6, 1'b1});
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_total++;
      if (sw_db[6] !== 1'b0) $display("FAIL async_early: tick %0d got sw_db6=%b want 0", k, sw_db[6]);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({sw_db[6], rise[6]} !== 2'b11) $display("FAIL async_commit: got sw_db/rise=%b want 11", {sw_db[6], rise[6]});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_bounce();
    test_simultaneous();
    test_overrun();
    test_fall();
    test_async_reset();
    repeat (5) tick();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d queued events want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
